// File: rtl/dl_port_responder.sv
// Responder for the download toggle req/ack port; byte writes are paired into 16-bit backend writes.
// Latency: a buffered write is acked 1 edge after the request is seen; reads finish on the edge where mem_rdy is high.
// Backpressure: ack is withheld while the buffer drains or a backend read is in flight (mem_cs held until mem_rdy).
module dl_port_responder #(
    parameter int AW  = 23,
    parameter int TMO = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          req,
    output logic          ack,
    input  logic [AW-1:0] a,
    input  logic [1:0]    ds,
    input  logic          we,
    input  logic [15:0]   d,
    output logic [15:0]   q,
    input  logic          flush,
    output logic          busy,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WFLUSH = 2'd1,
        RD     = 2'd2
    } state_t;

    // Idle timer only needs to reach TMO-1; keep at least one bit so TMO of 0 or 1 still elaborates.
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    state_t          state, nxt_state;
    logic            buf_v, nxt_buf_v;
    logic [AW-1:0]   buf_addr, nxt_buf_addr;
    logic [1:0]      buf_be, nxt_buf_be;
    logic [15:0]     buf_data, nxt_buf_data;
    logic [TW-1:0]   timer, nxt_timer;

    logic            nxt_ack;
    logic [15:0]     nxt_q;
    logic            nxt_busy;
    logic            nxt_mem_cs;
    logic            nxt_mem_we;
    logic [1:0]      nxt_mem_be;
    logic [AW-1:0]   nxt_mem_addr;
    logic [15:0]     nxt_mem_wdata;

    logic            pending;
    logic            tmo_hit;
    logic            enter_wr;
    logic            enter_rd;
    logic [1:0]      merged_be;
    logic [15:0]     base_data;

    assign pending = req ^ ack;
    assign tmo_hit = (TMO > 0) && (timer == TW'(TMO - 1));

    // Next-state and next-register values; backend outputs only change when WFLUSH/RD is entered or left.
    always_comb begin
        nxt_state     = state;
        nxt_buf_v     = buf_v;
        nxt_buf_addr  = buf_addr;
        nxt_buf_be    = buf_be;
        nxt_buf_data  = buf_data;
        nxt_timer     = timer;
        nxt_ack       = ack;
        nxt_q         = q;
        nxt_mem_cs    = mem_cs;
        nxt_mem_we    = mem_we;
        nxt_mem_be    = mem_be;
        nxt_mem_addr  = mem_addr;
        nxt_mem_wdata = mem_wdata;
        enter_wr      = 1'b0;
        enter_rd      = 1'b0;
        // An empty buffer starts from zero so unwritten lanes go out as 0x00.
        merged_be     = (buf_v ? buf_be : 2'b00) | ds;
        base_data     = buf_v ? buf_data : 16'h0000;

        case (state)
            IDLE: begin
                if (pending && we) begin
                    if (ds == 2'b00) begin
                        nxt_ack = req;
                    end else if (!buf_v || (buf_addr == a)) begin
                        nxt_buf_v    = 1'b1;
                        nxt_buf_addr = a;
                        nxt_buf_be   = merged_be;
                        nxt_buf_data = {ds[1] ? d[15:8] : base_data[15:8],
                                        ds[0] ? d[7:0]  : base_data[7:0]};
                        nxt_ack      = req;
                        nxt_timer    = '0;
                        enter_wr     = (merged_be == 2'b11);
                    end else begin
                        // Different word: drain the old one, leave the request pending.
                        enter_wr = 1'b1;
                    end
                end else if (pending) begin
                    // Reads drain the buffer first so they never see stale backend data.
                    if (buf_v) begin
                        enter_wr = 1'b1;
                    end else begin
                        enter_rd = 1'b1;
                    end
                end else if (buf_v) begin
                    if (flush || tmo_hit) begin
                        enter_wr = 1'b1;
                    end else begin
                        nxt_timer = timer + TW'(1);
                    end
                end
            end
            WFLUSH: begin
                if (mem_rdy) begin
                    nxt_state  = IDLE;
                    nxt_mem_cs = 1'b0;
                    nxt_mem_we = 1'b0;
                    nxt_buf_v  = 1'b0;
                    nxt_buf_be = 2'b00;
                    nxt_timer  = '0;
                end
            end
            RD: begin
                if (mem_rdy) begin
                    nxt_state  = IDLE;
                    nxt_mem_cs = 1'b0;
                    nxt_q      = mem_rdata;
                    nxt_ack    = req;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        if (enter_wr) begin
            nxt_state     = WFLUSH;
            nxt_mem_cs    = 1'b1;
            nxt_mem_we    = 1'b1;
            nxt_mem_be    = nxt_buf_be;
            nxt_mem_addr  = nxt_buf_addr;
            nxt_mem_wdata = nxt_buf_data;
        end else if (enter_rd) begin
            nxt_state    = RD;
            nxt_mem_cs   = 1'b1;
            nxt_mem_we   = 1'b0;
            nxt_mem_be   = 2'b11;
            nxt_mem_addr = a;
        end

        nxt_busy = (nxt_state != IDLE) | nxt_buf_v;
    end

    // State, buffer and all outputs registered; synchronous reset discards any buffered word.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            buf_v     <= 1'b0;
            buf_addr  <= '0;
            buf_be    <= 2'b00;
            buf_data  <= 16'h0000;
            timer     <= '0;
            ack       <= 1'b0;
            q         <= 16'h0000;
            busy      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
        end else begin
            state     <= nxt_state;
            buf_v     <= nxt_buf_v;
            buf_addr  <= nxt_buf_addr;
            buf_be    <= nxt_buf_be;
            buf_data  <= nxt_buf_data;
            timer     <= nxt_timer;
            ack       <= nxt_ack;
            q         <= nxt_q;
            busy      <= nxt_busy;
            mem_cs    <= nxt_mem_cs;
            mem_we    <= nxt_mem_we;
            mem_be    <= nxt_mem_be;
            mem_addr  <= nxt_mem_addr;
            mem_wdata <= nxt_mem_wdata;
        end
    end

endmodule
